// File: rtl/walu_core.sv
// Registered integer ALU: one operation per cycle, result and status flags
// appear one clock after the request with out_valid asserted.
module walu_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative,
   output logic             err
);

   localparam int SW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOR  = 4'd5;
   localparam logic [3:0] OP_SLL  = 4'd6;
   localparam logic [3:0] OP_SRL  = 4'd7;
   localparam logic [3:0] OP_SRA  = 4'd8;
   localparam logic [3:0] OP_SLT  = 4'd9;
   localparam logic [3:0] OP_SLTU = 4'd10;
   localparam logic [3:0] OP_PASS = 4'd11;

   // Widen a single compare bit to a full result word.
   function automatic logic [WIDTH-1:0] to_word(input logic bit_i);
      return {{(WIDTH-1){1'b0}}, bit_i};
   endfunction

   function automatic logic [WIDTH-1:0] sra(input logic [WIDTH-1:0] val,
                                            input logic [SW-1:0]    sh);
      logic signed [WIDTH-1:0] sval;
      sval = $signed(val);
      return sval >>> sh;
   endfunction

   logic [SW-1:0]    sh_w;
   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   dif_w;
   logic             add_ovf_w;
   logic             sub_ovf_w;

   logic [WIDTH-1:0] res_d, res_q;
   logic             carry_d, carry_q;
   logic             ovf_d, ovf_q;
   logic             zero_d, zero_q;
   logic             neg_d, neg_q;
   logic             err_d, err_q;
   logic             vld_q;

   // Only the low log2(WIDTH) bits of b form the shift amount.
   assign sh_w  = b[SW-1:0];
   assign sum_w = {1'b0, a} + {1'b0, b};
   // SUB as a + ~b + 1 so the top bit is "no borrow".
   assign dif_w = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

   assign add_ovf_w = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
   assign sub_ovf_w = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      res_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
      unique case (op)
         OP_ADD: begin
            res_d   = sum_w[WIDTH-1:0];
            carry_d = sum_w[WIDTH];
            ovf_d   = add_ovf_w;
         end
         OP_SUB: begin
            res_d   = dif_w[WIDTH-1:0];
            carry_d = dif_w[WIDTH];
            ovf_d   = sub_ovf_w;
         end
         OP_AND:  res_d = a & b;
         OP_OR:   res_d = a | b;
         OP_XOR:  res_d = a ^ b;
         OP_NOR:  res_d = ~(a | b);
         OP_SLL:  res_d = a << sh_w;
         OP_SRL:  res_d = a >> sh_w;
         OP_SRA:  res_d = sra(a, sh_w);
         OP_SLT:  res_d = to_word($signed(a) < $signed(b));
         OP_SLTU: res_d = to_word(a < b);
         OP_PASS: res_d = b;
         default: err_d = 1'b1;
      endcase
      zero_d = (res_d == '0);
      neg_d  = res_d[WIDTH-1];
   end

   // Result register; flags only update on a valid request so they hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q   <= 1'b0;
         res_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         vld_q <= in_valid;
         if (in_valid) begin
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
         end
      end
   end

   assign out_valid = vld_q;
   assign result    = res_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;
   assign negative  = neg_q;
   assign err       = err_q;

endmodule

// File: tb/tb_walu_core.sv
// Bench for walu_core: directed corner cases followed by random traffic,
// compared against an arithmetic reference model.
module tb_walu_core;

   localparam int W = 32;

   typedef struct {
      logic         vld;
      logic [W-1:0] r;
      logic         c;
      logic         v;
      logic         z;
      logic         n;
      logic         e;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [3:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic [W-1:0] result;
   logic         carry;
   logic         overflow;
   logic         zero;
   logic         negative;
   logic         err;

   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t held;
   exp_t zeros;

   walu_core #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .a(a), .b(b),
      .out_valid(out_valid), .result(result), .carry(carry),
      .overflow(overflow), .zero(zero), .negative(negative), .err(err)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y);
      exp_t          m;
      longint unsigned ux, uy, md, s;
      longint        sx, sy, ss, lo, hi;
      int            sh;
      ux = x; uy = y;
      sx = $signed(x); sy = $signed(y);
      md = 64'd1 << W;
      hi = (64'sd1 <<< (W - 1)) - 1;
      lo = -(64'sd1 <<< (W - 1));
      sh = int'(uy % W);
      m.vld = 1'b1; m.r = '0; m.c = 1'b0; m.v = 1'b0; m.e = 1'b0;
      case (o)
         4'd0: begin
            s = ux + uy; m.r = W'(s % md); m.c = (s >= md);
            ss = sx + sy; m.v = (ss > hi) || (ss < lo);
         end
         4'd1: begin
            m.r = W'((ux + md - uy) % md); m.c = (ux >= uy);
            ss = sx - sy; m.v = (ss > hi) || (ss < lo);
         end
         4'd2:  m.r = x & y;
         4'd3:  m.r = x | y;
         4'd4:  m.r = x ^ y;
         4'd5:  m.r = ~(x | y);
         4'd6:  m.r = W'((ux << sh) % md);
         4'd7:  m.r = W'(ux >> sh);
         4'd8:  m.r = W'(sx >>> sh);
         4'd9:  m.r = (sx < sy) ? W'(1) : W'(0);
         4'd10: m.r = (ux < uy) ? W'(1) : W'(0);
         4'd11: m.r = y;
         default: m.e = 1'b1;
      endcase
      m.z = (m.r == '0);
      m.n = m.r[W-1];
      return m;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(e.vld));
      chk({tag, ".result"},    64'(result),    64'(e.r));
      chk({tag, ".carry"},     64'(carry),     64'(e.c));
      chk({tag, ".overflow"},  64'(overflow),  64'(e.v));
      chk({tag, ".zero"},      64'(zero),      64'(e.z));
      chk({tag, ".negative"},  64'(negative),  64'(e.n));
      chk({tag, ".err"},       64'(err),       64'(e.e));
   endtask

   // Drive one request at the falling edge, check the registered outcome after the rising edge.
   task automatic step(input string tag, input logic v, input logic [3:0] o,
                       input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      in_valid = v; op = o; a = x; b = y;
      @(posedge clk);
      #1;
      if (v) held = model(o, x, y);
      else   held.vld = 1'b0;
      chk_all(tag, held);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return W'(1);
         2: return '1;
         3: return {1'b1, {(W-1){1'b0}}};
         4: return {1'b0, {(W-1){1'b1}}};
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      zeros = '{vld: 1'b0, r: '0, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0, e: 1'b0};
      held  = zeros;
      rst_n = 1'b0; in_valid = 1'b1; op = 4'd0; a = 32'd7; b = 32'd9;
      repeat (3) @(posedge clk);
      #1 chk_all("reset", zeros);
      @(negedge clk);
      rst_n = 1'b1;

      step("add2p3",   1'b1, 4'd0,  32'd2,        32'd3);
      step("addcarry", 1'b1, 4'd0,  32'hFFFFFFFF, 32'd1);
      step("addovf",   1'b1, 4'd0,  32'h7FFFFFFF, 32'd1);
      step("sub3m5",   1'b1, 4'd1,  32'd3,        32'd5);
      step("sub5m5",   1'b1, 4'd1,  32'd5,        32'd5);
      step("subovf",   1'b1, 4'd1,  32'h80000000, 32'd1);
      step("sra",      1'b1, 4'd8,  32'h80000000, 32'h24);
      step("srl",      1'b1, 4'd7,  32'h80000000, 32'h24);
      step("sll31",    1'b1, 4'd6,  32'd1,        32'd31);
      step("sll0",     1'b1, 4'd6,  32'h12345678, 32'h40);
      step("slt",      1'b1, 4'd9,  32'hFFFFFFFF, 32'd1);
      step("sltu",     1'b1, 4'd10, 32'hFFFFFFFF, 32'd1);
      step("illegal",  1'b1, 4'd13, 32'h55, 32'hAA);

      // Four back-to-back ops, then idle cycles that must hold the last result.
      step("b2b0", 1'b1, 4'd2,  32'hF0F0F0F0, 32'hFF00FF00);
      step("b2b1", 1'b1, 4'd3,  32'h0000000F, 32'h000000F0);
      step("b2b2", 1'b1, 4'd5,  32'h0F0F0F0F, 32'h00FF00FF);
      step("b2b3", 1'b1, 4'd11, 32'hDEADBEEF, 32'hCAFEF00D);
      step("idle0", 1'b0, 4'd0, 32'd1, 32'd1);
      step("idle1", 1'b0, 4'd4, 32'd9, 32'd3);

      // Asynchronous reset mid-stream clears outputs without waiting for a clock.
      step("prerst", 1'b1, 4'd1, 32'd1, 32'd2);
      @(negedge clk);
      in_valid = 1'b1; op = 4'd0; a = 32'd4; b = 32'd4;
      #2 rst_n = 1'b0;
      #1 chk_all("asyncrst", zeros);
      held = zeros;
      @(negedge clk);
      rst_n = 1'b1;
      step("postrst", 1'b1, 4'd0, 32'd10, 32'd20);

      for (int i = 0; i < 300; i++) begin
         step($sformatf("rnd%0d", i), ($urandom_range(0, 3) != 0),
              4'($urandom_range(0, 15)), pick(), pick());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
